// File: rtl/game_pkg.sv
// Shared types and constants for the pong match controller.
package game_pkg;

   localparam int SCORE_W = 4;
   localparam int FRAME_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      PAUSE = 3'd4,
      OVER  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_L    = 2'b01,
      WIN_R    = 2'b10
   } winner_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the match controller and the ball mover / display.
interface game_ctrl_if;
   import game_pkg::*;

   logic               VSync;
   logic               StartBtn;
   logic               PauseBtn;
   logic               LftCollision;
   logic               RgtCollision;
   logic               BallEn;
   logic               BallRst;
   logic [SCORE_W-1:0] ScoreL;
   logic [SCORE_W-1:0] ScoreR;
   logic [1:0]         Winner;
   logic [2:0]         GameState;

   modport master (
      output VSync, StartBtn, PauseBtn, LftCollision, RgtCollision,
      input  BallEn, BallRst, ScoreL, ScoreR, Winner, GameState
   );

   modport slave (
      input  VSync, StartBtn, PauseBtn, LftCollision, RgtCollision,
      output BallEn, BallRst, ScoreL, ScoreR, Winner, GameState
   );

endinterface

// File: rtl/game_ctrl_btn_sync.sv
// Two-flop synchroniser for an asynchronous pushbutton followed by a
// rising-edge detector producing a single-cycle event.
module btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   // [0],[1] synchronise; [2] remembers the previous synchronised level
   logic [2:0] sh_q, sh_d;

   always_comb begin
      sh_d = {sh_q[1:0], btn};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sh_q <= '0;
      else        sh_q <= sh_d;
   end

   assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/game_ctrl.sv
// Pong match sequencer: serve countdown, play, pause, scoring and game over.
// All outputs are registered; events are derived from registered edge detects.
module game_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60
) (
   input  logic        clk,
   input  logic        reset,
   game_ctrl_if.slave  gif
);

   localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
   localparam logic [FRAME_W-1:0] SERVE_LD = FRAME_W'(SERVE_FRAMES);

   // ---- event generation ----
   logic start_ev, pause_ev;

   btn_sync u_start (.clk(clk), .reset(reset), .btn(gif.StartBtn), .pulse(start_ev));
   btn_sync u_pause (.clk(clk), .reset(reset), .btn(gif.PauseBtn), .pulse(pause_ev));

   logic vs_q, vs_d;
   logic lc_q, lc_d;
   logic rc_q, rc_d;
   logic tick, l_ev, r_ev;

   always_comb begin
      vs_d = gif.VSync;
      lc_d = gif.LftCollision;
      rc_d = gif.RgtCollision;
   end

   assign tick = ~gif.VSync & vs_q;
   assign l_ev = gif.LftCollision & ~lc_q;
   assign r_ev = gif.RgtCollision & ~rc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_q <= 1'b0;
         lc_q <= 1'b0;
         rc_q <= 1'b0;
      end else begin
         vs_q <= vs_d;
         lc_q <= lc_d;
         rc_q <= rc_d;
      end
   end

   // ---- match state ----
   state_t             state_q, state_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d;
   logic [SCORE_W-1:0] score_r_q, score_r_d;
   winner_t            winner_q, winner_d;
   logic               ball_en_q, ball_en_d;
   logic               ball_rst_q, ball_rst_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         score_l_q   <= '0;
         score_r_q   <= '0;
         winner_q    <= WIN_NONE;
         ball_en_q   <= 1'b0;
         ball_rst_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         winner_q    <= winner_d;
         ball_en_q   <= ball_en_d;
         ball_rst_q  <= ball_rst_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      winner_d    = winner_q;
      ball_rst_d  = 1'b0;

      case (state_q)
         IDLE, OVER: begin
            if (start_ev) begin
               score_l_d   = '0;
               score_r_d   = '0;
               winner_d    = WIN_NONE;
               ball_rst_d  = 1'b1;
               frame_cnt_d = SERVE_LD;
               state_d     = SERVE;
            end
         end
         SERVE: begin
            if (tick) begin
               frame_cnt_d = frame_cnt_q - 1'b1;
               if (frame_cnt_q == FRAME_W'(1)) state_d = PLAY;
            end
         end
         PLAY: begin
            // a collision always takes priority over a same-cycle pause
            if (l_ev && r_ev) begin
               ball_rst_d  = 1'b1;
               frame_cnt_d = SERVE_LD;
               state_d     = SERVE;
            end else if (l_ev) begin
               if (score_r_q < WIN_S) score_r_d = score_r_q + 1'b1;
               state_d = POINT;
            end else if (r_ev) begin
               if (score_l_q < WIN_S) score_l_d = score_l_q + 1'b1;
               state_d = POINT;
            end else if (pause_ev) begin
               state_d = PAUSE;
            end
         end
         POINT: begin
            if (score_l_q == WIN_S) begin
               winner_d = WIN_L;
               state_d  = OVER;
            end else if (score_r_q == WIN_S) begin
               winner_d = WIN_R;
               state_d  = OVER;
            end else begin
               ball_rst_d  = 1'b1;
               frame_cnt_d = SERVE_LD;
               state_d     = SERVE;
            end
         end
         PAUSE: begin
            if (pause_ev) state_d = PLAY;
         end
         default: state_d = IDLE;
      endcase

      // registered copy of "next state is PLAY" so BallEn drops with the score
      ball_en_d = (state_d == PLAY);
   end

   assign gif.BallEn    = ball_en_q;
   assign gif.BallRst   = ball_rst_q;
   assign gif.ScoreL    = score_l_q;
   assign gif.ScoreR    = score_r_q;
   assign gif.Winner    = winner_q;
   assign gif.GameState = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: serve, scoring, win, pause, tie-hit and reset.
module tb_game_ctrl;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   game_ctrl_if gif ();

   game_ctrl #(.WIN_SCORE(9), .SERVE_FRAMES(60)) dut (
      .clk   (clk),
      .reset (reset),
      .gif   (gif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      gif.VSync = 1'b0;
      step();
      gif.VSync = 1'b1;
      step();
   endtask

   task automatic serve_to_play();
      repeat (60) frame();
   endtask

   // one-cycle collision pulse followed by the POINT cycle and one more
   task automatic point(input bit left);
      if (left) gif.LftCollision = 1'b1;
      else      gif.RgtCollision = 1'b1;
      step();
      gif.LftCollision = 1'b0;
      gif.RgtCollision = 1'b0;
      step();
      step();
   endtask

   task automatic press_start();
      gif.StartBtn = 1'b1;
      repeat (3) step();
      gif.StartBtn = 1'b0;
      step();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset            = 1'b0;
      gif.VSync        = 1'b1;
      gif.StartBtn     = 1'b0;
      gif.PauseBtn     = 1'b0;
      gif.LftCollision = 1'b0;
      gif.RgtCollision = 1'b0;
      #23;
      chk("rst_state", gif.GameState, 0);
      chk("rst_ballen", gif.BallEn, 0);
      chk("rst_ballrst", gif.BallRst, 0);
      chk("rst_scorel", gif.ScoreL, 0);
      chk("rst_scorer", gif.ScoreR, 0);
      chk("rst_winner", gif.Winner, 0);
      step();
      reset = 1'b1;
      step();

      // start: state changes on the third edge after the press, held button = one event
      gif.StartBtn = 1'b1;
      step(); step();
      chk("start_lat2_state", gif.GameState, 0);
      chk("start_lat2_rst", gif.BallRst, 0);
      step();
      chk("start_state", gif.GameState, 1);
      chk("start_ballrst", gif.BallRst, 1);
      step();
      chk("start_ballrst_once", gif.BallRst, 0);
      repeat (4) step();
      gif.StartBtn = 1'b0;
      chk("start_held_state", gif.GameState, 1);

      repeat (59) frame();
      chk("serve_59", gif.GameState, 1);
      chk("serve_59_en", gif.BallEn, 0);
      frame();
      chk("serve_60", gif.GameState, 2);
      chk("serve_60_en", gif.BallEn, 1);

      // held left-wall hit: score counts once, one clk after the rise
      gif.LftCollision = 1'b1;
      step();
      chk("lhit_scorer", gif.ScoreR, 1);
      chk("lhit_state", gif.GameState, 3);
      chk("lhit_en", gif.BallEn, 0);
      chk("lhit_norst", gif.BallRst, 0);
      step();
      chk("lhit_ballrst", gif.BallRst, 1);
      chk("lhit_serve", gif.GameState, 1);
      step();
      chk("lhit_ballrst_off", gif.BallRst, 0);
      step();
      gif.LftCollision = 1'b0;
      step();
      chk("lhit_held_scorer", gif.ScoreR, 1);
      chk("lhit_held_scorel", gif.ScoreL, 0);

      // left player climbs to 8
      repeat (8) begin
         serve_to_play();
         point(1'b0);
      end
      chk("l8_scorel", gif.ScoreL, 8);
      chk("l8_state", gif.GameState, 1);
      chk("l8_winner", gif.Winner, 0);

      serve_to_play();
      gif.RgtCollision = 1'b1;
      step();
      chk("win_scorel", gif.ScoreL, 9);
      chk("win_point", gif.GameState, 3);
      step();
      chk("win_winner", gif.Winner, 1);
      chk("win_over", gif.GameState, 5);
      chk("win_en", gif.BallEn, 0);
      chk("win_norst", gif.BallRst, 0);
      gif.RgtCollision = 1'b0;
      step();
      point(1'b0);
      chk("over_hit_scorel", gif.ScoreL, 9);
      chk("over_hit_state", gif.GameState, 5);
      chk("over_hit_winner", gif.Winner, 1);

      // restart from OVER
      gif.StartBtn = 1'b1;
      repeat (3) step();
      chk("restart_state", gif.GameState, 1);
      chk("restart_scorel", gif.ScoreL, 0);
      chk("restart_scorer", gif.ScoreR, 0);
      chk("restart_winner", gif.Winner, 0);
      chk("restart_ballrst", gif.BallRst, 1);
      gif.StartBtn = 1'b0;
      step();

      // pause, ignored collision, resume
      serve_to_play();
      gif.PauseBtn = 1'b1;
      repeat (3) step();
      chk("pause_state", gif.GameState, 4);
      chk("pause_en", gif.BallEn, 0);
      repeat (4) step();
      gif.PauseBtn = 1'b0;
      chk("pause_held", gif.GameState, 4);
      step();
      point(1'b1);
      chk("pause_hit_scorer", gif.ScoreR, 0);
      chk("pause_hit_state", gif.GameState, 4);
      gif.PauseBtn = 1'b1;
      repeat (3) step();
      chk("resume_state", gif.GameState, 2);
      chk("resume_en", gif.BallEn, 1);
      gif.PauseBtn = 1'b0;
      step();

      // simultaneous wall hits: no score, re-serve
      gif.LftCollision = 1'b1;
      gif.RgtCollision = 1'b1;
      step();
      chk("tie_state", gif.GameState, 1);
      chk("tie_ballrst", gif.BallRst, 1);
      chk("tie_scorel", gif.ScoreL, 0);
      chk("tie_scorer", gif.ScoreR, 0);
      gif.LftCollision = 1'b0;
      gif.RgtCollision = 1'b0;
      step();

      // build 3:5, pause, then reset mid-match
      repeat (3) begin
         serve_to_play();
         point(1'b0);
      end
      repeat (5) begin
         serve_to_play();
         point(1'b1);
      end
      serve_to_play();
      gif.PauseBtn = 1'b1;
      repeat (3) step();
      gif.PauseBtn = 1'b0;
      chk("pre_rst_state", gif.GameState, 4);
      chk("pre_rst_scorel", gif.ScoreL, 3);
      chk("pre_rst_scorer", gif.ScoreR, 5);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_state", gif.GameState, 0);
      chk("mid_rst_scorel", gif.ScoreL, 0);
      chk("mid_rst_scorer", gif.ScoreR, 0);
      chk("mid_rst_en", gif.BallEn, 0);
      chk("mid_rst_winner", gif.Winner, 0);
      chk("mid_rst_ballrst", gif.BallRst, 0);
      step();
      reset = 1'b1;
      step();
      press_start();
      chk("post_rst_state", gif.GameState, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
